// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state codes and control field encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JUMP   = 4'd10
   } state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_outputs.sv
// rtl/multicycle_ctrl_outputs.sv - combinational decode of the current state into datapath controls
module multicycle_ctrl_outputs
   import mips_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic       mem_ready,
   input  logic [5:0] op,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic       instr_done,
   output logic       illegal_op
);

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ALUSrcB     = SRCB_B;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (state)
         S_FETCH: begin
            // IR and PC only load once the instruction word is actually back
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB    = SRCB_IMM_SH;
            illegal_op = !op_is_legal(op);
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            // store completes on the ready cycle, so a stalled store pulses done once
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM: state register and next-state logic
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcB,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_e state_q;
   state_e state_d;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (Op == OP_LW)
               state_d = S_MEMRD;
            else if (Op == OP_SW)
               state_d = S_MEMWR;
            else
               state_d = S_FETCH;
         end
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // async reset so an in-flight write enable drops without waiting for an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   assign state = state_q;

   multicycle_ctrl_outputs u_outputs (
      .state       (state_q),
      .mem_ready   (mem_ready),
      .op          (Op),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .ALUSrcB     (ALUSrcB),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with randomized instruction stream
module tb_multicycle_control;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4;
   localparam int ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7, ST_RWB = 8, ST_BEQ = 9, ST_JUMP = 10;
   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
   localparam logic [5:0] O_BEQ = 6'b000100, O_J = 6'b000010, O_BAD = 6'b111111;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd;
      logic [1:0] pcs, aop, asb;
      logic       done, ill;
   } ctrl_t;

   typedef struct packed {
      logic [3:0] st;
      ctrl_t      c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic [3:0] state;
   ctrl_t      act;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   int   cyc = 0;
   int   done_seen = 0, done_exp = 0, ill_seen = 0, ill_exp = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcB(ALUSrcB), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                 RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, instr_done, illegal_op};

   function automatic bit legal(input logic [5:0] op);
      return op inside {O_R, O_LW, O_SW, O_BEQ, O_J};
   endfunction

   // Expected controls for one cycle, written from the per-step control lists
   function automatic ctrl_t model(input int st, input logic mr, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (st)
         ST_FETCH:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
         ST_DECODE: begin c.asb = 2'b11; c.ill = !legal(op); end
         ST_MEMADR: begin c.asa = 1; c.asb = 2'b10; end
         ST_MEMRD:  begin c.mrd = 1; c.iord = 1; end
         ST_MEMWB:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
         ST_MEMWR:  begin c.mwr = 1; c.iord = 1; c.done = mr; end
         ST_EXEC:   begin c.asa = 1; c.aop = 2'b10; end
         ST_RWB:    begin c.rw = 1; c.rd = 1; c.done = 1; end
         ST_BEQ:    begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; end
         ST_JUMP:   begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   task automatic step(input int st, input logic mr, input logic [5:0] op);
      exp_t x;
      @(posedge clk);
      #1;
      mem_ready = mr;
      Op = op;
      x.st = 4'(st);
      x.c  = model(st, mr, op);
      q.push_back(x);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
      for (int i = 0; i < fstall; i++) step(ST_FETCH, 1'b0, op);
      step(ST_FETCH, 1'b1, op);
      step(ST_DECODE, rbit(), op);
      if (op == O_LW || op == O_SW) begin
         step(ST_MEMADR, rbit(), op);
         if (op == O_LW) begin
            for (int i = 0; i < mstall; i++) step(ST_MEMRD, 1'b0, op);
            step(ST_MEMRD, 1'b1, op);
            step(ST_MEMWB, rbit(), op);
         end else begin
            for (int i = 0; i < mstall; i++) step(ST_MEMWR, 1'b0, op);
            step(ST_MEMWR, 1'b1, op);
         end
      end else if (op == O_R) begin
         step(ST_EXEC, rbit(), op);
         step(ST_RWB, rbit(), op);
      end else if (op == O_BEQ) begin
         step(ST_BEQ, rbit(), op);
      end else if (op == O_J) begin
         step(ST_JUMP, rbit(), op);
      end
      if (legal(op)) done_exp++;
      else ill_exp++;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         cyc++;
         if (instr_done === 1'b1) done_seen++;
         if (illegal_op === 1'b1) ill_seen++;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow cycle=%0d state=%0d", cyc, state);
         end else begin
            e = q.pop_front();
            if ({state, act} !== e) begin
               failures++;
               $display("FAIL cycle_%0d state=%0d ctrl=%05h expected state=%0d ctrl=%05h",
                        cyc, state, act, e.st, e.c);
            end
         end
      end
   end

   initial begin
      exp_t idle_rec;
      logic [5:0] ops[5];
      logic [5:0] op;
      ops = '{O_R, O_LW, O_SW, O_BEQ, O_J};
      idle_rec = '0;
      Op = O_R;
      mem_ready = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outputs", 32'(act), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.push_back(idle_rec);
      mon_en = 1'b1;

      run_instr(O_R, 0, 0);
      run_instr(O_LW, 0, 2);
      run_instr(O_SW, 0, 0);
      run_instr(O_BEQ, 0, 0);
      run_instr(O_J, 0, 0);
      run_instr(O_BAD, 0, 0);
      run_instr(O_LW, 1, 0);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            op = 6'($urandom);
            while (legal(op)) op = 6'($urandom);
         end else begin
            op = ops[$urandom_range(0, 4)];
         end
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Abort a stalled store with an asynchronous reset
      step(ST_FETCH, 1'b1, O_SW);
      step(ST_DECODE, 1'b1, O_SW);
      step(ST_MEMADR, 1'b1, O_SW);
      step(ST_MEMWR, 1'b0, O_SW);
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("abort_memwrite", 32'(MemWrite), 32'd0);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_outputs", 32'(act), 32'd0);
      chk("abort_queue_drained", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
      chk("abort_hold_outputs", 32'(act), 32'd0);
      reset = 1'b0;
      q.push_back(idle_rec);
      mon_en = 1'b1;
      run_instr(O_R, 0, 0);
      run_instr(O_SW, 0, 1);

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("final_queue_empty", 32'(q.size()), 32'd0);
      chk("instr_done_count", 32'(done_seen), 32'(done_exp));
      chk("illegal_op_count", 32'(ill_seen), 32'(ill_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
